// File: rtl/data_mem_responder.sv
// Data-memory responder: word-addressed synchronous RAM that answers MemRead/MemWrite after
// WAIT_CYCLES wait states. Define DMEM_BYTE_WRITE_EN to add per-byte write enables (Byte_Sel).
module data_mem_responder #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                MemRead,
   input  logic                MemWrite,
   input  logic [ADDR_W-1:0]   Adress,
   input  logic [DATA_W-1:0]   Write_Data,
`ifdef DMEM_BYTE_WRITE_EN
   input  logic [DATA_W/8-1:0] Byte_Sel,
`endif
   output logic [DATA_W-1:0]   Read_Data,
   output logic                Ready,
   output logic                Busy,
   output logic                Error
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
`ifdef DMEM_BYTE_WRITE_EN
   localparam int unsigned NBYTES = DATA_W / 8;
`endif

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e            state_q;
   logic [3:0]        cnt_q;
   logic              op_write_q;
   logic              err_q;
   logic [IDX_W-1:0]  idx_q;
   logic [DATA_W-1:0] wdata_q;
`ifdef DMEM_BYTE_WRITE_EN
   logic [NBYTES-1:0] bsel_q;
`endif

   logic [DATA_W-1:0] ram [DEPTH];

   logic              req;
   logic              req_err;
   logic [ADDR_W-1:0] word_addr;
   logic [IDX_W-1:0]  req_idx;
   logic              wr_commit;

   assign req       = MemRead | MemWrite;
   assign word_addr = {2'b00, Adress[ADDR_W-1:2]};
   assign req_idx   = Adress[IDX_W+1:2];
   // Out-of-range word addresses are rejected rather than wrapped onto a valid index.
   assign req_err   = (MemRead & MemWrite) | (Adress[1:0] != 2'b00) |
                      (word_addr >= ADDR_W'(DEPTH));
   assign wr_commit = (state_q == StResp) & op_write_q & ~err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= 4'd0;
         op_write_q <= 1'b0;
         err_q      <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= '0;
`ifdef DMEM_BYTE_WRITE_EN
         bsel_q     <= '0;
`endif
         Read_Data  <= '0;
         Ready      <= 1'b0;
         Busy       <= 1'b0;
         Error      <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req) begin
                  op_write_q <= MemWrite;
                  err_q      <= req_err;
                  idx_q      <= req_idx;
                  wdata_q    <= Write_Data;
`ifdef DMEM_BYTE_WRITE_EN
                  bsel_q     <= Byte_Sel;
`endif
                  if (WAIT_CYCLES == 0) begin
                     state_q <= StResp;
                     Ready   <= ~req_err;
                     Error   <= req_err;
                     if (MemRead && !req_err) Read_Data <= ram[req_idx];
                  end else begin
                     state_q <= StWait;
                     Busy    <= 1'b1;
                     cnt_q   <= 4'(WAIT_CYCLES);
                  end
               end
            end
            StWait: begin
               if (cnt_q <= 4'd1) begin
                  state_q <= StResp;
                  cnt_q   <= 4'd0;
                  Busy    <= 1'b0;
                  Ready   <= ~err_q;
                  Error   <= err_q;
                  if (!op_write_q && !err_q) Read_Data <= ram[idx_q];
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StResp: begin
               state_q <= StIdle;
               Ready   <= 1'b0;
               Error   <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               Ready   <= 1'b0;
               Error   <= 1'b0;
               Busy    <= 1'b0;
            end
         endcase
      end
   end

   // Writes land on the edge leaving RESP, so the next accepted request already sees them.
   always_ff @(posedge clk) begin
      if (wr_commit) begin
`ifdef DMEM_BYTE_WRITE_EN
         for (int b = 0; b < int'(NBYTES); b++) begin
            if (bsel_q[b]) ram[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
         end
`else
         ram[idx_q] <= wdata_q;
`endif
      end
   end

   ready_error_exclusive_a : assert property (@(posedge clk) disable iff (rst)
      !(Ready && Error));
   busy_only_in_wait_a : assert property (@(posedge clk) disable iff (rst)
      Busy == (state_q == StWait));

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: table-driven requests on a WAIT_CYCLES=2 instance, a
// WAIT_CYCLES=0 instance, reset abort and back-to-back sequences, scoreboard-checked responses.
module tb_data_mem_responder;

   typedef struct {
      logic        err;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_data;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read   [2];
   logic        mem_write  [2];
   logic [31:0] adress     [2];
   logic [31:0] write_data [2];
   logic [31:0] read_data  [2];
   logic        ready      [2];
   logic        busy       [2];
   logic        error      [2];
`ifdef DMEM_BYTE_WRITE_EN
   logic [3:0]  byte_sel   [2];
   logic [3:0]  cur_bsel = 4'hF;
`endif

   exp_t sb_a[$];
   exp_t sb_b[$];
   vec_t vecs[12];
   int   n_checks = 0;
   int   n_pass = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(2)) dut_a (
      .clk(clk), .rst(rst), .MemRead(mem_read[0]), .MemWrite(mem_write[0]),
      .Adress(adress[0]), .Write_Data(write_data[0]),
`ifdef DMEM_BYTE_WRITE_EN
      .Byte_Sel(byte_sel[0]),
`endif
      .Read_Data(read_data[0]), .Ready(ready[0]), .Busy(busy[0]), .Error(error[0]));

   data_mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(0)) dut_b (
      .clk(clk), .rst(rst), .MemRead(mem_read[1]), .MemWrite(mem_write[1]),
      .Adress(adress[1]), .Write_Data(write_data[1]),
`ifdef DMEM_BYTE_WRITE_EN
      .Byte_Sel(byte_sel[1]),
`endif
      .Read_Data(read_data[1]), .Ready(ready[1]), .Busy(busy[1]), .Error(error[1]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
   endtask

   // Scoreboard: every Ready/Error pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      int   sz;
      if (!rst) begin
         for (int s = 0; s < 2; s++) begin
            if (ready[s] || error[s]) begin
               check("ready_error_exclusive", 32'(ready[s] & error[s]), 32'd0);
               sz = (s == 0) ? sb_a.size() : sb_b.size();
               if (sz == 0) begin
                  check("response_expected", 32'(sz), 32'd1);
               end else begin
                  e = (s == 0) ? sb_a.pop_front() : sb_b.pop_front();
                  check("response_error_flag", 32'(error[s]), 32'(e.err));
                  check("response_read_data", read_data[s], e.data);
               end
            end
         end
      end
   end

   task automatic do_req(input int s, input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic exp_err,
                         input logic [31:0] exp_data, input string name);
      int   lat;
      int   nbusy;
      bit   seen;
      exp_t e;
      int   wc;
      wc = (s == 0) ? 2 : 0;
      @(negedge clk);
      mem_read[s]   = rd;
      mem_write[s]  = wr;
      adress[s]     = addr;
      write_data[s] = wdata;
`ifdef DMEM_BYTE_WRITE_EN
      byte_sel[s]   = cur_bsel;
`endif
      e.err  = exp_err;
      e.data = exp_data;
      if (s == 0) sb_a.push_back(e);
      else sb_b.push_back(e);
      @(posedge clk);
      #1;
      // Garbage while the request is in flight; it must not be sampled.
      mem_read[s]   = 1'b1;
      mem_write[s]  = 1'b1;
      adress[s]     = $urandom;
      write_data[s] = $urandom;
      lat   = 0;
      nbusy = 0;
      seen  = 1'b0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         if (busy[s]) nbusy++;
         if (ready[s] || error[s]) seen = 1'b1;
      end
      mem_read[s]  = 1'b0;
      mem_write[s] = 1'b0;
      check({name, " latency"}, 32'(lat), 32'(wc + 1));
      check({name, " busy_cycles"}, 32'(nbusy), 32'(wc));
   endtask

   initial begin
      int          rc [3];
      logic [31:0] b2b_addr [3];
      rst = 1'b1;
      for (int s = 0; s < 2; s++) begin
         mem_read[s]   = 1'b0;
         mem_write[s]  = 1'b0;
         adress[s]     = 32'd0;
         write_data[s] = 32'd0;
`ifdef DMEM_BYTE_WRITE_EN
         byte_sel[s]   = 4'hF;
`endif
      end

      //           rd    wr    addr          wdata          err   read_data
      vecs[0]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0101_0101, 1'b0, 32'h0000_0000};
      vecs[1]  = '{1'b0, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
      vecs[2]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
      vecs[3]  = '{1'b0, 1'b1, 32'h0000_0008, 32'h0BAD_F00D, 1'b0, 32'hDEAD_BEEF};
      vecs[4]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF};
      vecs[5]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF};
      vecs[6]  = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
      vecs[7]  = '{1'b1, 1'b1, 32'h0000_0004, 32'h5555_5555, 1'b1, 32'hCAFE_F00D};
      vecs[8]  = '{1'b1, 1'b0, 32'h0000_0006, 32'h0000_0000, 1'b1, 32'hCAFE_F00D};
      vecs[9]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h6666_6666, 1'b1, 32'hCAFE_F00D};
      vecs[10] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
      vecs[11] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0101_0101};

      @(negedge clk);
      check("reset read_data", read_data[0], 32'd0);
      check("reset ready", 32'(ready[0]), 32'd0);
      check("reset busy", 32'(busy[0]), 32'd0);
      check("reset error", 32'(error[0]), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         do_req(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_err,
                vecs[i].exp_data, $sformatf("vec%0d", i));
      end

      // Zero wait states: response on the cycle after accept, Busy never set.
      do_req(1, 1'b0, 1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 1'b0, 32'h0000_0000, "w0 write");
      do_req(1, 1'b1, 1'b0, 32'h0000_03FC, 32'h0000_0000, 1'b0, 32'hA5A5_A5A5, "w0 read");
      do_req(1, 1'b1, 1'b0, 32'h0000_0400, 32'h0000_0000, 1'b1, 32'hA5A5_A5A5, "w0 oob");

`ifdef DMEM_BYTE_WRITE_EN
      cur_bsel = 4'hF;
      do_req(0, 1'b0, 1'b1, 32'h0000_0020, 32'h1122_3344, 1'b0, 32'h0101_0101, "bw full");
      cur_bsel = 4'b0101;
      do_req(0, 1'b0, 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 1'b0, 32'h0101_0101, "bw partial");
      cur_bsel = 4'b0000;
      do_req(0, 1'b0, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 1'b0, 32'h0101_0101, "bw none");
      cur_bsel = 4'b1010;
      do_req(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'h11BB_33DD, "bw read");
      cur_bsel = 4'hF;
`endif

      // Reset in the middle of a write's wait states: nothing commits, nothing pulses.
      @(negedge clk);
      mem_write[0]  = 1'b1;
      adress[0]     = 32'h0000_0010;
      write_data[0] = 32'hFFFF_0000;
      @(posedge clk);
      #1;
      mem_write[0] = 1'b0;
      @(negedge clk);
      check("abort busy_before_reset", 32'(busy[0]), 32'd1);
      rst = 1'b1;
      #1;
      check("abort read_data", read_data[0], 32'd0);
      check("abort busy", 32'(busy[0]), 32'd0);
      check("abort ready", 32'(ready[0]), 32'd0);
      check("abort error", 32'(error[0]), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      do_req(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h1234_5678, "abort reread");

      // Back-to-back reads with MemRead held high.
      b2b_addr[0] = 32'h0;
      b2b_addr[1] = 32'h4;
      b2b_addr[2] = 32'h8;
      sb_a.push_back('{1'b0, 32'h0101_0101});
      sb_a.push_back('{1'b0, 32'hDEAD_BEEF});
      sb_a.push_back('{1'b0, 32'h0BAD_F00D});
      @(negedge clk);
      mem_read[0]  = 1'b1;
      mem_write[0] = 1'b0;
      adress[0]    = b2b_addr[0];
      for (int k = 0; k < 3; k++) begin
         int lim;
         bit got;
         lim   = 0;
         got   = 1'b0;
         rc[k] = 0;
         while (!got && lim < 20) begin
            @(negedge clk);
            lim++;
            if (ready[0] || error[0]) begin
               got          = 1'b1;
               rc[k]        = cyc;
               mem_write[0] = 1'b0;
               if (k < 2) adress[0] = b2b_addr[k+1];
               else mem_read[0] = 1'b0;
            end else if (busy[0]) begin
               mem_write[0] = 1'b1;
               adress[0]    = 32'h0000_0006;
            end
         end
         check($sformatf("b2b response%0d seen", k), 32'(got), 32'd1);
      end
      mem_read[0]  = 1'b0;
      mem_write[0] = 1'b0;
      check("b2b gap01", 32'(rc[1] - rc[0]), 32'd4);
      check("b2b gap12", 32'(rc[2] - rc[1]), 32'd4);

      repeat (8) @(negedge clk);
      check("scoreboard drained", 32'(sb_a.size() + sb_b.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
